fetch_unit: RTL and testbench

//  Instruction fetch stage feeding the core's decoder. Keeps a PC, issues in-order

---
 rtl/fetch_unit.sv | 176 +++++++++++++++++
 tb/tb_fetch_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, credit-limited in-order imem requests, response FIFO
// and valid/ready delivery of {pc, instruction} to the decoder. A redirect flushes
// everything in flight; responses still owed by memory are counted off in FLUSH.
// Optional build macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect target yields
// a single fault entry (FAULT), after which fetch halts until the next redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [2:0] {ST_FETCH, ST_STALL, ST_FLUSH, ST_FAULT, ST_HALT} state_t;
`else
  typedef enum logic [1:0] {ST_FETCH, ST_STALL, ST_FLUSH} state_t;
`endif

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   out_q, out_d;        // requests accepted, response not yet seen
  logic [CW-1:0]   drop_q, drop_d;      // responses still to be discarded
  logic [CW-1:0]   fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
  logic [AW-1:0]   tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic [31:0]     fifo_pc_q   [DEPTH];
  logic [31:0]     fifo_data_q [DEPTH];
  logic [31:0]     tag_q       [DEPTH];
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            fifo_flt_q  [DEPTH];
  logic            fault_pend_q, fault_pend_d;
  logic [31:0]     fault_pc_q, fault_pc_d;
  logic            push_flt;
`endif

  logic [CW-1:0]   occ;
  logic [CW:0]     credit_sum;
  logic            credit, acc, pop, resp_keep, resp_drop, push_en;
  logic [31:0]     push_pc, push_data;

  // Credit covers both buffered entries and responses still owed by memory, so a
  // response can always be pushed; the sum only rises on accept, keeping req stable.
  assign occ            = fifo_wp_q - fifo_rp_q;
  assign credit_sum     = {1'b0, out_q} + {1'b0, occ};
  assign credit         = credit_sum < (CW+1)'(DEPTH);
  assign imem_req_valid = !rst && (state_q == ST_FETCH || state_q == ST_STALL) && credit;
  assign imem_req_addr  = fetch_pc_q;
  assign acc            = imem_req_valid && imem_req_ready;
  assign resp_keep      = imem_resp_valid && (drop_q == '0);
  assign resp_drop      = imem_resp_valid && (drop_q != '0);
  assign inst_valid     = fifo_wp_q != fifo_rp_q;
  assign pop            = inst_valid && inst_ready;
  assign inst_pc        = fifo_pc_q[fifo_rp_q[AW-1:0]];
  assign inst_data      = fifo_data_q[fifo_rp_q[AW-1:0]];
`ifdef FETCH_MISALIGN_CHECK_EN
  assign inst_fault     = inst_valid && fifo_flt_q[fifo_rp_q[AW-1:0]];
`else
  assign inst_fault     = 1'b0;
`endif

  // Next-state: normal fetch bookkeeping, then redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = acc ? fetch_pc_q + 32'd4 : fetch_pc_q;
    out_d      = out_q + CW'(acc) - CW'(imem_resp_valid);
    drop_d     = drop_q - CW'(resp_drop);
    push_en    = resp_keep;
    push_pc    = tag_q[tag_rp_q];
    push_data  = imem_resp_data;
    tag_wp_d   = tag_wp_q + AW'(acc);
    tag_rp_d   = tag_rp_q + AW'(resp_keep);
`ifdef FETCH_MISALIGN_CHECK_EN
    push_flt     = 1'b0;
    fault_pend_d = fault_pend_q;
    fault_pc_d   = fault_pc_q;
`endif
    case (state_q)
      ST_FETCH: if (!credit) state_d = ST_STALL;
      ST_STALL: if (credit) state_d = ST_FETCH;
      ST_FLUSH: if (drop_d == '0) begin
`ifdef FETCH_MISALIGN_CHECK_EN
        state_d = fault_pend_q ? ST_FAULT : ST_FETCH;
`else
        state_d = ST_FETCH;
`endif
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      ST_FAULT: begin
        push_en   = 1'b1;
        push_pc   = fault_pc_q;
        push_data = 32'h00000013;
        push_flt  = 1'b1;
        state_d   = ST_HALT;
      end
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_FETCH;
    endcase
    fifo_wp_d = fifo_wp_q + CW'(push_en);
    fifo_rp_d = fifo_rp_q + CW'(pop);
    if (redirect_valid) begin
      push_en   = 1'b0;
      fifo_wp_d = '0;
      fifo_rp_d = '0;
      tag_wp_d  = '0;
      tag_rp_d  = '0;
      drop_d    = out_d;   // every response still owed, incl. one accepted now
`ifdef FETCH_MISALIGN_CHECK_EN
      fetch_pc_d   = redirect_pc;
      fault_pend_d = redirect_pc[1:0] != 2'b00;
      fault_pc_d   = redirect_pc;
      state_d      = (drop_d != '0) ? ST_FLUSH : (fault_pend_d ? ST_FAULT : ST_FETCH);
`else
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      state_d    = (drop_d != '0) ? ST_FLUSH : ST_FETCH;
`endif
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      fifo_wp_q  <= '0;
      fifo_rp_q  <= '0;
      tag_wp_q   <= '0;
      tag_rp_q   <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_pend_q <= 1'b0;
      fault_pc_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      fifo_wp_q  <= fifo_wp_d;
      fifo_rp_q  <= fifo_rp_d;
      tag_wp_q   <= tag_wp_d;
      tag_rp_q   <= tag_rp_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_pend_q <= fault_pend_d;
      fault_pc_q   <= fault_pc_d;
`endif
    end
  end

  // Storage arrays: validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_en) begin
      fifo_pc_q[fifo_wp_q[AW-1:0]]   <= push_pc;
      fifo_data_q[fifo_wp_q[AW-1:0]] <= push_data;
`ifdef FETCH_MISALIGN_CHECK_EN
      fifo_flt_q[fifo_wp_q[AW-1:0]]  <= push_flt;
`endif
    end
    if (acc) tag_q[tag_wp_q] <= fetch_pc_q;
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with an in-order, fixed-latency
// instruction memory model returning ~addr as the instruction word.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready, inst_fault;
  logic [31:0] inst_data, inst_pc;

  int errors = 0;
  int checks = 0;
  int lat = 1;
  int cyc = 0;
  logic [64:0] e;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mq[$];
  logic [64:0] dq[$];   // delivered {fault, pc, data}
  logic [31:0] rq[$];   // accepted request addresses

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h80000000), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .inst_fault(inst_fault)
  );

  // Memory model: in order, response shown lat cycles after acceptance.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      mq.delete();
      imem_resp_valid <= 1'b0;
      imem_resp_data  <= '0;
    end else begin
      if (imem_resp_valid) void'(mq.pop_front());
      if (imem_req_valid && imem_req_ready) mq.push_back(mreq_t'{imem_req_addr, cyc + lat - 1});
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= ~mq[0].addr;
      end else begin
        imem_resp_valid <= 1'b0;
      end
    end
  end

  // Monitor: handshakes in a redirect cycle do not count as transfers.
  always @(posedge clk) begin
    if (!rst && !redirect_valid) begin
      if (inst_valid && inst_ready) dq.push_back({inst_fault, inst_pc, inst_data});
      if (imem_req_valid && imem_req_ready) rq.push_back(imem_req_addr);
    end
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] dget(input int i);
    if (i < dq.size()) return dq[i];
    return 'x;
  endfunction

  function automatic logic [31:0] rget(input int i);
    if (i < rq.size()) return rq[i];
    return 'x;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    dq.delete();
    rq.delete();
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    dq.delete();
    rq.delete();
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_fault", inst_fault, 0);
    chk("rst_req_addr", imem_req_addr, 32'h80000000);

    // 1: latency 1, always ready -> one instruction per cycle
    dq.delete(); rq.delete(); lat = 1; rst = 1'b0;
    #1 chk("t1_first_req", {imem_req_valid, imem_req_addr}, {1'b1, 32'h80000000});
    repeat (12) @(negedge clk);
    chk("t1_count", dq.size(), 10);
    for (int i = 0; i < 10; i++) begin
      e = dget(i);
      chk("t1_entry", e, {1'b0, 32'h80000000 + 32'(4*i), ~(32'h80000000 + 32'(4*i))});
    end

    // 2: core stalled -> exactly DEPTH requests, FIFO full, then lossless drain
    inst_ready = 1'b0; lat = 1;
    do_reset();
    repeat (20) @(negedge clk);
    chk("t2_req_count", rq.size(), 4);
    chk("t2_req_valid", imem_req_valid, 0);
    chk("t2_inst_valid", inst_valid, 1);
    chk("t2_head_pc", inst_pc, 32'h80000000);
    chk("t2_none_popped", dq.size(), 0);
    inst_ready = 1'b1;
    repeat (16) @(negedge clk);
    chk("t2_drained", dq.size() >= 12, 1);
    for (int i = 0; i < 12; i++) begin
      e = dget(i);
      chk("t2_entry", e, {1'b0, 32'h80000000 + 32'(4*i), ~(32'h80000000 + 32'(4*i))});
    end

    // 3: latency 3, redirect with 3 outstanding -> all 3 dropped
    lat = 3; inst_ready = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);
    chk("t3_outstanding", rq.size(), 3);
    imem_req_ready = 1'b0;
    redirect(32'h80000100);
    imem_req_ready = 1'b1;
    chk("t3_flush_no_req", imem_req_valid, 0);
    chk("t3_flush_no_inst", inst_valid, 0);
    repeat (10) @(negedge clk);
    e = dget(0);
    chk("t3_first", e, {1'b0, 32'h80000100, ~32'h80000100});
    e = dget(1);
    chk("t3_second", e, {1'b0, 32'h80000104, ~32'h80000104});

    // 4: redirect coinciding with accept, response and pop
    lat = 1;
    do_reset();
    repeat (6) @(negedge clk);
    chk("t4_busy", {imem_req_valid, imem_resp_valid, inst_valid}, 3'b111);
    redirect(32'h80000200);
    chk("t4_inst_valid_after", inst_valid, 0);
    repeat (8) @(negedge clk);
    chk("t4_first_req", rget(0), 32'h80000200);
    e = dget(0);
    chk("t4_first", e, {1'b0, 32'h80000200, ~32'h80000200});

    // 5: PC wrap at 2^32
    redirect(32'hFFFFFFFC);
    repeat (8) @(negedge clk);
    chk("t5_req0", rget(0), 32'hFFFFFFFC);
    chk("t5_req1", rget(1), 32'h00000000);
    e = dget(0);
    chk("t5_inst0", e, {1'b0, 32'hFFFFFFFC, 32'h00000003});
    e = dget(1);
    chk("t5_inst1", e, {1'b0, 32'h00000000, 32'hFFFFFFFF});

    // 6: misaligned redirect target
    redirect(32'h80000102);
    repeat (8) @(negedge clk);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("t6_one_entry", dq.size(), 1);
    e = dget(0);
    chk("t6_fault_entry", e, {1'b1, 32'h80000102, 32'h00000013});
    chk("t6_no_reqs", rq.size(), 0);
    chk("t6_req_valid", imem_req_valid, 0);
`else
    chk("t6_first_req", rget(0), 32'h80000100);
    e = dget(0);
    chk("t6_first", e, {1'b0, 32'h80000100, ~32'h80000100});
    chk("t6_fault_low", inst_fault, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
